spi_slave: RTL and testbench

Byte-oriented SPI slave for the far end of the link driven by `spimaster`. It consumes `Sclk`/`SS`/`MOSI` and drives `MISO`, and it runs entirely in the local `clk` domain by oversampling the SPI pins. It supports all four SPI modes and delivers received bytes to local logic with a valid/ack handshake. It accepts transmit bytes through a one-deep buffered load handshake.

---
 rtl/spi_slave.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_spi_slave.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// Byte-oriented SPI slave that oversamples the SPI pins in the local clk
// domain. It supports all four SPI modes (CPOL = MODE[1], CPHA = MODE[0]),
// delivers received frames through a valid/ack handshake and takes transmit
// frames through a one-deep buffered load handshake.
//
// Optional feature macro: SPI_SLAVE_OVERRUN_EN
//   defined   : `overrun` is a sticky flag. It sets on an RX overwrite or on
//               a TX transfer that finds the buffer empty, and clears on a
//               cycle with rx_ack=1 and no new error.
//   undefined : `overrun` is tied low and no logic is built for it.
//
// Parameters:
//   WIDTH        frame length in bits (bit counter is $clog2(WIDTH)+1 wide)
//   SYNC_STAGES  synchronizer depth on Sclk/SS/MOSI, minimum 2
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous reset, active-low
//   MODE      in   SPI mode, latched when a frame starts
//   Sclk      in   SPI clock from the master (asynchronous)
//   SS        in   slave select, active-low (asynchronous)
//   MOSI      in   serial data in, MSB first
//   MISO      out  serial data out, MSB first, 0 while SS is high
//   TxData    in   next frame to transmit
//   tx_load   in   writes TxData into the TX buffer when tx_ready is high
//   tx_ready  out  TX buffer empty
//   RxData    out  last received frame, held until the next one completes
//   rx_valid  out  a received frame is pending until rx_ack
//   rx_ack    in   consumes the pending frame
//   busy      out  a frame is in progress
//   overrun   out  sticky error flag (see macro above)
// -----------------------------------------------------------------------------
module spi_slave #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       MODE,
  input  logic             Sclk,
  input  logic             SS,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] TxData,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] RxData,
  output logic             rx_valid,
  input  logic             rx_ack,
  output logic             busy,
  output logic             overrun
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Pin synchronizers and edge history
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q,   ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   ss_hist_q,   ss_hist_d;
  // Marks when the history flop holds a real pin sample rather than a reset
  // value, so a reset taken while SS is low cannot fake an SS fall.
  logic [SYNC_STAGES:0]   fill_q,      fill_d;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall;
  logic lead_edge, trail_edge;
  logic sample_edge, shift_edge;
  logic ss_fall, ss_rise;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  state_t           state_q,    state_d;
  logic [1:0]       mode_q,     mode_d;
  logic [CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
  logic [WIDTH-2:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] tx_buf_q,   tx_buf_d;
  logic             tx_ready_q, tx_ready_d;
  logic [WIDTH-1:0] rx_data_q,  rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             miso_q,     miso_d;
  logic             busy_q,     busy_d;

  logic [WIDTH-1:0] rx_next;
  logic [WIDTH-1:0] tx_word;
  logic             tx_take;
  logic             rx_done;

  // An empty buffer transmits all zeros.
  assign tx_word = tx_ready_q ? {WIDTH{1'b0}} : tx_buf_q;

  // Next values of the synchronizer chains and history flops.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], Sclk};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    sclk_hist_d = sclk_s;
    ss_hist_d   = ss_s;
    fill_d      = {fill_q[SYNC_STAGES-1:0], 1'b1};
  end

  // Synchronizer registers; Sclk flops reset to the idle level of the mode.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sync_q <= {SYNC_STAGES{MODE[1]}};
      ss_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= {SYNC_STAGES{1'b1}};
      sclk_hist_q <= MODE[1];
      ss_hist_q   <= 1'b1;
      fill_q      <= {(SYNC_STAGES + 1){1'b0}};
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_hist_q <= sclk_hist_d;
      ss_hist_q   <= ss_hist_d;
      fill_q      <= fill_d;
    end
  end

  // Edge decode: leading/trailing follow CPOL, sample/shift follow CPHA.
  always_comb begin
    sclk_rise   = sclk_s & ~sclk_hist_q;
    sclk_fall   = ~sclk_s & sclk_hist_q;
    lead_edge   = mode_q[1] ? sclk_fall : sclk_rise;
    trail_edge  = mode_q[1] ? sclk_rise : sclk_fall;
    sample_edge = mode_q[0] ? trail_edge : lead_edge;
    shift_edge  = mode_q[0] ? lead_edge : trail_edge;
    ss_fall     = fill_q[SYNC_STAGES] & ss_hist_q & ~ss_s;
    ss_rise     = ss_s & ~ss_hist_q;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, shift datapath and handshake logic.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    tx_buf_d   = tx_buf_q;
    tx_ready_d = tx_ready_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    miso_d     = miso_q;
    tx_take    = 1'b0;
    rx_done    = 1'b0;
    rx_next    = {rx_shift_q, mosi_s};

    case (state_q)
      ST_IDLE: begin
        miso_d    = 1'b0;
        bit_cnt_d = {CNT_W{1'b0}};
        if (ss_fall) begin
          state_d = ST_LOAD;
          mode_d  = MODE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (ss_rise) begin
          state_d = ST_IDLE;
          miso_d  = 1'b0;
        end else begin
          state_d = ST_SHIFT;
          tx_take = 1'b1;
          if (mode_q[0]) begin
            // CPHA=1: first bit goes out on the first leading edge.
            tx_shift_d = tx_word;
            miso_d     = 1'b0;
          end else begin
            // CPHA=0: first bit is presented right away, the rest follow.
            tx_shift_d = {tx_word[WIDTH-2:0], 1'b0};
            miso_d     = tx_word[WIDTH-1];
          end
        end
      end

      ST_SHIFT: begin
        if (ss_rise) begin
          // Early SS rise drops any partial frame.
          state_d    = ST_IDLE;
          bit_cnt_d  = {CNT_W{1'b0}};
          rx_shift_d = {(WIDTH - 1){1'b0}};
          miso_d     = 1'b0;
        end else if (sample_edge) begin
          rx_shift_d = rx_next[WIDTH-2:0];
          if (bit_cnt_q == CNT_LAST) begin
            // Frame complete: publish it and reload TX for a back-to-back frame.
            bit_cnt_d  = {CNT_W{1'b0}};
            rx_done    = 1'b1;
            rx_data_d  = rx_next;
            tx_shift_d = tx_word;
            tx_take    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
          end
        end else if (shift_edge) begin
          miso_d     = tx_shift_q[WIDTH-1];
          tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
        end else begin
          state_d = ST_SHIFT;
        end
      end

      default: begin
        state_d = ST_IDLE;
        miso_d  = 1'b0;
      end
    endcase

    // A load in the same cycle as a transfer wins: the buffer stays full.
    if (tx_load && tx_ready_q) begin
      tx_buf_d   = TxData;
      tx_ready_d = 1'b0;
    end else if (tx_take) begin
      tx_ready_d = 1'b1;
    end else begin
      tx_ready_d = tx_ready_q;
    end

    // A completing frame beats a simultaneous ack.
    if (rx_done) begin
      rx_valid_d = 1'b1;
    end else if (rx_ack) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q     <= 2'b00;
      bit_cnt_q  <= {CNT_W{1'b0}};
      rx_shift_q <= {(WIDTH - 1){1'b0}};
      tx_shift_q <= {WIDTH{1'b0}};
      tx_buf_q   <= {WIDTH{1'b0}};
      tx_ready_q <= 1'b1;
      rx_data_q  <= {WIDTH{1'b0}};
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      tx_buf_q   <= tx_buf_d;
      tx_ready_q <= tx_ready_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= miso_d;
      busy_q     <= busy_d;
    end
  end

  assign MISO     = miso_q;
  assign tx_ready = tx_ready_q;
  assign RxData   = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

`ifdef SPI_SLAVE_OVERRUN_EN
  logic overrun_q, overrun_d;
  logic ovr_err;

  // Sticky error: RX overwrite without ack, or TX transfer from an empty buffer.
  always_comb begin
    ovr_err = (rx_done & rx_valid_q & ~rx_ack) | (tx_take & tx_ready_q);
    if (ovr_err) begin
      overrun_d = 1'b1;
    end else if (rx_ack) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Overrun flag register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a simple SPI master with 4-clk
// half-periods, RX/MISO scoreboards and a monitor that acks received frames.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] MODE;
  logic       Sclk;
  logic       SS;
  logic       MOSI;
  logic       MISO;
  logic [7:0] TxData;
  logic       tx_load;
  logic       tx_ready;
  logic [7:0] RxData;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       busy;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;
  int rx_events = 0;

  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_miso_q[$];

  bit         mon_en = 1'b1;
  bit         manual_ack = 1'b0;
  bit         pend_load = 1'b0;
  logic [7:0] pend_data = 8'h00;

  spi_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .MODE    (MODE),
    .Sclk    (Sclk),
    .SS      (SS),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .TxData  (TxData),
    .tx_load (tx_load),
    .tx_ready(tx_ready),
    .RxData  (RxData),
    .rx_valid(rx_valid),
    .rx_ack  (rx_ack),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // RX monitor: compares each received frame with the scoreboard and acks it.
  always begin
    @(posedge clk);
    #2;
    if (mon_en) begin
      if (rx_valid && !rx_ack) begin
        rx_events++;
        check("rx_expected_pending", 32'(exp_rx_q.size() != 0), 32'd1);
        if (exp_rx_q.size() != 0) check("rx_data", 32'(RxData), 32'(exp_rx_q.pop_front()));
        rx_ack = 1'b1;
      end else begin
        rx_ack = 1'b0;
      end
    end else begin
      if (rx_valid && !rx_ack && manual_ack) rx_events++;
      rx_ack = manual_ack;
    end
  end

  // Advance n clocks; handles single-cycle tx_load pulses, including deferred ones.
  task automatic wait_clks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_load = 1'b0;
      if (pend_load) begin
        TxData    = pend_data;
        tx_load   = 1'b1;
        exp_miso_q.push_back(pend_data);
        pend_load = 1'b0;
      end
    end
  endtask

  task automatic load_tx(input logic [7:0] v);
    TxData  = v;
    tx_load = 1'b1;
    exp_miso_q.push_back(v);
    wait_clks(1);
    check("tx_ready_after_load", 32'(tx_ready), 32'd0);
  endtask

  task automatic set_mode(input logic [1:0] m);
    MODE = m;
    Sclk = m[1];
    wait_clks(6);
  endtask

  task automatic ss_low();
    SS = 1'b0;
    wait_clks(6);
  endtask

  task automatic ss_high();
    wait_clks(4);
    SS = 1'b1;
    wait_clks(6);
    check("miso_idle", 32'(MISO), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  // Master side of one frame (or nbits of it); load_bit<0 means no mid-frame load.
  task automatic xfer(input logic [7:0] tx, input int nbits, input bit first,
                      input int load_bit, output logic [7:0] rx);
    logic cpol;
    logic cpha;
    cpol = MODE[1];
    cpha = MODE[0];
    rx   = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (i == load_bit) pend_load = 1'b1;
      if (!cpha) MOSI = tx[7-i];
      wait_clks(4);
      if (cpha && first && i == 0) check("cpha1_first_bit_held", 32'(MISO), 32'd0);
      Sclk = ~cpol;
      if (cpha) MOSI = tx[7-i];
      else      rx = {rx[6:0], MISO};
      wait_clks(4);
      Sclk = cpol;
      if (cpha) rx = {rx[6:0], MISO};
    end
  endtask

  task automatic expect_miso(input logic [7:0] got);
    check("miso_expected_pending", 32'(exp_miso_q.size() != 0), 32'd1);
    if (exp_miso_q.size() != 0) check("miso_byte", 32'(got), 32'(exp_miso_q.pop_front()));
  endtask

  initial begin
    logic [7:0] got;
    int         ev0;
    logic       exp_ovr;
`ifdef SPI_SLAVE_OVERRUN_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif
    rst = 1'b0; MODE = 2'b00; Sclk = 1'b0; SS = 1'b1; MOSI = 1'b1;
    TxData = 8'h00; tx_load = 1'b0;
    wait_clks(4);
    check("rst_miso",     32'(MISO),     32'd0);
    check("rst_rxdata",   32'(RxData),   32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_overrun",  32'(overrun),  32'd0);
    rst = 1'b1;
    wait_clks(4);

    // Mode 0 basic frame; a second load while the buffer is full is ignored.
    load_tx(8'hA5);
    TxData  = 8'hFF;
    tx_load = 1'b1;
    wait_clks(1);
    ss_low();
    check("busy_in_frame", 32'(busy), 32'd1);
    exp_rx_q.push_back(8'h3C);
    xfer(8'h3C, 8, 1'b1, -1, got);
    expect_miso(got);
    ss_high();
    check("tx_ready_after_frame", 32'(tx_ready), 32'd1);

    // Modes 1..3.
    for (int m = 1; m < 4; m++) begin
      set_mode(2'(m));
      load_tx(8'h7E);
      ss_low();
      exp_rx_q.push_back(8'h81);
      xfer(8'h81, 8, 1'b1, -1, got);
      expect_miso(got);
      ss_high();
    end

    // Mode 3 with an MSB of 1: first bit must wait for the first leading edge.
    load_tx(8'hFF);
    ss_low();
    exp_rx_q.push_back(8'h00);
    xfer(8'h00, 8, 1'b1, -1, got);
    expect_miso(got);
    ss_high();

    // Back-to-back frames in one SS window with a reload between them.
    set_mode(2'b00);
    load_tx(8'hC3);
    ss_low();
    exp_rx_q.push_back(8'h12);
    exp_rx_q.push_back(8'h34);
    pend_data = 8'h56;
    xfer(8'h12, 8, 1'b1, 3, got);
    expect_miso(got);
    xfer(8'h34, 8, 1'b0, -1, got);
    expect_miso(got);
    ss_high();

    // Abort after 5 bits, then a full frame.
    ev0 = rx_events;
    ss_low();
    xfer(8'hFF, 5, 1'b1, -1, got);
    ss_high();
    check("abort_no_rx", 32'(rx_events), 32'(ev0));
    check("abort_bit_cnt", 32'(dut.bit_cnt_q), 32'd0);
    check("abort_rx_valid", 32'(rx_valid), 32'd0);
    load_tx(8'h5A);
    ss_low();
    exp_rx_q.push_back(8'hF0);
    xfer(8'hF0, 8, 1'b1, -1, got);
    expect_miso(got);
    ss_high();

    // Two frames without ack; empty TX buffer sends zeros.
    mon_en = 1'b0;
    exp_miso_q.push_back(8'h00);
    ss_low();
    xfer(8'h11, 8, 1'b1, -1, got);
    expect_miso(got);
    ss_high();
    check("noack_rx_valid1", 32'(rx_valid), 32'd1);
    check("noack_rxdata1", 32'(RxData), 32'h11);
    exp_miso_q.push_back(8'h00);
    ss_low();
    xfer(8'h22, 8, 1'b1, -1, got);
    expect_miso(got);
    ss_high();
    check("noack_rx_valid2", 32'(rx_valid), 32'd1);
    check("noack_rxdata2", 32'(RxData), 32'h22);
    check("overrun_set", 32'(overrun), 32'(exp_ovr));
    manual_ack = 1'b1;
    wait_clks(2);
    manual_ack = 1'b0;
    wait_clks(2);
    check("ack_clears_valid", 32'(rx_valid), 32'd0);
    check("ack_clears_overrun", 32'(overrun), 32'd0);
    mon_en = 1'b1;
    wait_clks(2);

    // Reset at bit 3 of a frame; remainder of that frame must be ignored.
    TxData  = 8'hE7;
    tx_load = 1'b1;
    wait_clks(1);
    ss_low();
    xfer(8'hAA, 3, 1'b1, -1, got);
    rst = 1'b0;
    wait_clks(1);
    check("midrst_miso",     32'(MISO),     32'd0);
    check("midrst_rxdata",   32'(RxData),   32'd0);
    check("midrst_rx_valid", 32'(rx_valid), 32'd0);
    check("midrst_tx_ready", 32'(tx_ready), 32'd1);
    check("midrst_busy",     32'(busy),     32'd0);
    check("midrst_overrun",  32'(overrun),  32'd0);
    rst = 1'b1;
    ev0 = rx_events;
    xfer(8'hAA, 5, 1'b0, -1, got);
    check("midrst_ignored_busy", 32'(busy), 32'd0);
    ss_high();
    check("midrst_no_rx", 32'(rx_events), 32'(ev0));
    load_tx(8'h69);
    ss_low();
    exp_rx_q.push_back(8'h96);
    xfer(8'h96, 8, 1'b1, -1, got);
    expect_miso(got);
    ss_high();

    wait_clks(10);
    check("rx_queue_drained", 32'(exp_rx_q.size()), 32'd0);
    check("miso_queue_drained", 32'(exp_miso_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
